// File: rtl/writeback_regfile.sv
// Write-back stage and register file: commits execute results, services LW through a
// req/ack data-memory read, and supplies registered operands rsv/rtv to the execute stage.
module writeback_regfile #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        state,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] result,
  input  logic              result_valid,
  output logic [DATA_W-1:0] rsv,
  output logic [DATA_W-1:0] rtv,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_done
);

  // Local copies of the sequencer state and opcode encodings shared with the rest of the core.
  localparam logic [2:0] StateRf = 3'd1;
  localparam logic [2:0] StateEx = 3'd2;
  localparam logic [2:0] StateWb = 3'd3;

  localparam logic [5:0] OpAddu  = 6'd1;
  localparam logic [5:0] OpSubu  = 6'd2;
  localparam logic [5:0] OpSlt   = 6'd3;
  localparam logic [5:0] OpAddiu = 6'd4;
  localparam logic [5:0] OpLw    = 6'd5;

  typedef enum logic [0:0] {StIdle, StLoadWait} fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] rsv_q, rsv_d, rtv_q, rtv_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              wb_done_q, wb_done_d;
  logic [4:0]        ld_dest_q, ld_dest_d;

  logic              we;
  logic              we_eff;
  logic [4:0]        waddr;
  logic [DATA_W-1:0] wdata;

  logic unused_state_ex;
  assign unused_state_ex = (state == StateEx);

  always_comb begin
    fsm_d      = fsm_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    ld_dest_d  = ld_dest_q;
    wb_done_d  = 1'b0;
    we         = 1'b0;
    waddr      = rd;
    wdata      = result;
    unique case (fsm_q)
      StIdle: begin
        if (state == StateWb) begin
          if (!result_valid) begin
            wb_done_d = 1'b1;
          end else if (opcode == OpLw) begin
            mem_req_d  = 1'b1;
            mem_addr_d = result;
            ld_dest_d  = rt;
            fsm_d      = StLoadWait;
          end else begin
            wb_done_d = 1'b1;
            case (opcode)
              OpAddu, OpSubu, OpSlt: begin
                we    = 1'b1;
                waddr = rd;
              end
              OpAddiu: begin
                we    = 1'b1;
                waddr = rt;
              end
              default: ;
            endcase
          end
        end
      end
      StLoadWait: begin
        // Destination was captured at request time so rt may change while waiting.
        if (mem_ack) begin
          we        = 1'b1;
          waddr     = ld_dest_q;
          wdata     = mem_rdata;
          mem_req_d = 1'b0;
          wb_done_d = 1'b1;
          fsm_d     = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  assign we_eff = we && (waddr != 5'd0);

  // Operand fetch with same-edge write bypass; r0 is never written so it always reads 0.
  always_comb begin
    rsv_d = rsv_q;
    rtv_d = rtv_q;
    if (state == StateRf) begin
      rsv_d = (we_eff && (waddr == rs)) ? wdata : regs_q[rs];
      rtv_d = (we_eff && (waddr == rt)) ? wdata : regs_q[rt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= StIdle;
      rsv_q      <= '0;
      rtv_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      wb_done_q  <= 1'b0;
      ld_dest_q  <= '0;
    end else begin
      fsm_q      <= fsm_d;
      rsv_q      <= rsv_d;
      rtv_q      <= rtv_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      wb_done_q  <= wb_done_d;
      ld_dest_q  <= ld_dest_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_eff) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rsv      = rsv_q;
  assign rtv      = rtv_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign wb_done  = wb_done_q;

endmodule
